// File: rtl/spi_master_gen.sv
// SPI master running entirely in the clk domain: SCLK comes from a clock-enable counter.
// Supports all CPOL/CPHA modes, MSB/LSB-first order and a per-transfer bit count.
module spi_master_gen #(
    parameter int DATA_W          = 32,
    parameter int SLAVE_COUNT     = 8,
    parameter int SLAVE_ADDRS_LEN = 3,
    parameter int DIV_W           = 8,
    parameter int LEN_W           = $clog2(DATA_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_trans,
    output logic                       busy,
    output logic                       done,
    input  logic [DATA_W-1:0]          tx_data,
    output logic [DATA_W-1:0]          rx_data,
    input  logic [SLAVE_ADDRS_LEN-1:0] chipADDRS,
    input  logic [LEN_W-1:0]           bit_count,
    input  logic [DIV_W-1:0]           division_ratio,
    input  logic                       CPOL,
    input  logic                       CPHA,
    input  logic                       lsb_first,
    input  logic                       default_val,
    output logic                       SPI_SCLK,
    output logic                       MOSI,
    input  logic                       MISO,
    output logic [SLAVE_COUNT-1:0]     CS
);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

    state_t                 r_state;
    logic [DIV_W-1:0]       r_cnt;
    logic [DIV_W-1:0]       r_div;
    logic [LEN_W:0]         r_half;
    logic [LEN_W-1:0]       r_nm1;
    logic [DATA_W-1:0]      r_tx;
    logic [DATA_W-1:0]      r_sh;
    logic [DATA_W-1:0]      r_rx;
    logic                   r_cpol;
    logic                   r_cpha;
    logic                   r_lsb;
    logic                   r_defv;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_sclk;
    logic                   r_mosi;
    logic [SLAVE_COUNT-1:0] r_cs;

    logic             w_addr_ok;
    logic [LEN_W-1:0] w_nm1_in;
    logic             w_first_in;
    logic             w_tick;
    logic             w_last;
    logic             w_edge;
    logic [LEN_W:0]   w_idx;
    logic [LEN_W-1:0] w_k;
    logic             w_lead;
    logic             w_sample;
    logic             w_shift;
    logic [LEN_W-1:0] w_rx_pos;
    logic [LEN_W-1:0] w_tx_k;
    logic [LEN_W-1:0] w_tx_pos;
    logic             w_tx_end;

    assign w_addr_ok  = 32'(chipADDRS) < 32'(SLAVE_COUNT);
    assign w_nm1_in   = (bit_count > LEN_W'(DATA_W-1)) ? LEN_W'(DATA_W-1) : bit_count;
    assign w_first_in = lsb_first ? tx_data[0] : tx_data[w_nm1_in];

    // w_idx is the half-period being entered on this SCLK toggle; even = leading edge.
    assign w_tick   = (r_cnt == r_div);
    assign w_last   = (r_half == {r_nm1, 1'b1});
    assign w_edge   = w_tick && ((r_state == S_LEAD) || ((r_state == S_XFER) && !w_last));
    assign w_idx    = (r_state == S_LEAD) ? '0 : r_half + (LEN_W+1)'(1);
    assign w_k      = w_idx[LEN_W:1];
    assign w_lead   = ~w_idx[0];
    assign w_sample = w_edge && (w_lead != r_cpha);
    assign w_shift  = w_edge && (w_lead == r_cpha);
    assign w_rx_pos = r_lsb ? w_k : r_nm1 - w_k;
    assign w_tx_k   = r_cpha ? w_k : w_k + LEN_W'(1);
    assign w_tx_pos = r_lsb ? w_tx_k : r_nm1 - w_tx_k;
    assign w_tx_end = !r_cpha && (w_k == r_nm1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_half  <= '0;
            r_nm1   <= '0;
            r_tx    <= '0;
            r_sh    <= '0;
            r_rx    <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            r_defv  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= CPOL;
            r_mosi  <= default_val;
            r_cs    <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sclk <= CPOL;
                    r_mosi <= default_val;
                    if (start_trans && w_addr_ok) begin
                        r_state <= S_LEAD;
                        r_busy  <= 1'b1;
                        r_cs    <= ~(SLAVE_COUNT'(1) << chipADDRS);
                        r_cnt   <= '0;
                        r_half  <= '0;
                        r_sh    <= '0;
                        r_tx    <= tx_data;
                        r_nm1   <= w_nm1_in;
                        r_div   <= division_ratio;
                        r_cpol  <= CPOL;
                        r_cpha  <= CPHA;
                        r_lsb   <= lsb_first;
                        r_defv  <= default_val;
                        r_mosi  <= CPHA ? default_val : w_first_in;
                    end
                end
                S_LEAD: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_half  <= '0;
                        r_state <= S_XFER;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                S_XFER: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (w_last) begin
                            r_state <= S_TRAIL;
                            if (r_cpha) r_mosi <= r_defv;
                        end else begin
                            r_half <= r_half + (LEN_W+1)'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                S_TRAIL: begin
                    if (w_tick) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_half  <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cs    <= '1;
                        r_rx    <= r_sh;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_edge)   r_sclk <= ~r_sclk;
            if (w_sample) r_sh[w_rx_pos] <= MISO;
            if (w_shift)  r_mosi <= w_tx_end ? r_defv : r_tx[w_tx_pos];
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rx_data  = r_rx;
    assign SPI_SCLK = r_sclk;
    assign MOSI     = r_mosi;
    assign CS       = r_cs;

endmodule

// File: tb/tb_spi_master_gen.sv
// Randomised self-checking bench for spi_master_gen against a behavioural SPI slave/reference model.
module tb_spi_master_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_trans = 1'b0;
    logic        busy, done;
    logic [31:0] tx_data = '0;
    logic [31:0] rx_data;
    logic [3:0]  chipADDRS = '0;
    logic [4:0]  bit_count = '0;
    logic [7:0]  division_ratio = '0;
    logic        CPOL = 1'b0, CPHA = 1'b0, lsb_first = 1'b0, default_val = 1'b0;
    logic        SPI_SCLK, MOSI, MISO;
    logic [7:0]  CS;
    logic        loopback = 1'b1;
    logic        s_miso = 1'b0;

    logic        start24 = 1'b0;
    logic        busy24, done24, sclk24, mosi24;
    logic [23:0] rx24;
    logic [7:0]  cs24;

    int n_checks = 0;
    int n_fail   = 0;

    assign MISO = loopback ? MOSI : s_miso;

    always #5 clk = ~clk;

    spi_master_gen #(.DATA_W(32), .SLAVE_COUNT(8), .SLAVE_ADDRS_LEN(4), .DIV_W(8)) u_dut (
        .clk(clk), .rst(rst), .start_trans(start_trans), .busy(busy), .done(done),
        .tx_data(tx_data), .rx_data(rx_data), .chipADDRS(chipADDRS), .bit_count(bit_count),
        .division_ratio(division_ratio), .CPOL(CPOL), .CPHA(CPHA), .lsb_first(lsb_first),
        .default_val(default_val), .SPI_SCLK(SPI_SCLK), .MOSI(MOSI), .MISO(MISO), .CS(CS)
    );

    spi_master_gen #(.DATA_W(24), .SLAVE_COUNT(8), .SLAVE_ADDRS_LEN(4), .DIV_W(8)) u_dut24 (
        .clk(clk), .rst(rst), .start_trans(start24), .busy(busy24), .done(done24),
        .tx_data(tx_data[23:0]), .rx_data(rx24), .chipADDRS(chipADDRS), .bit_count(bit_count),
        .division_ratio(division_ratio), .CPOL(CPOL), .CPHA(CPHA), .lsb_first(lsb_first),
        .default_val(default_val), .SPI_SCLK(sclk24), .MOSI(mosi24), .MISO(mosi24), .CS(cs24)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bit j the slave returns: the word is sent in the same order the master assembles it.
    function automatic logic slave_bit(input logic [31:0] w, input int n, input int j, input bit lsb);
        if (j >= n) return 1'b0;
        return lsb ? w[j] : w[n-1-j];
    endfunction

    task automatic run(input logic [31:0] tx, input logic [4:0] bc, input logic [7:0] dv,
                       input bit cpol, input bit cpha, input bit lsb, input bit defv,
                       input logic [3:0] addr, input bit loop, input logic [31:0] srx,
                       input bit chained, input bit hold, input bit disturb, input bit abort);
        int n, h, busy_c, done_c, lead_c, edge_c, samp, sidx, limit;
        bit prev, cs_bad, lead, seen_done;
        logic [31:0] mobs, mexp, mask, rexp;
        logic [7:0] cs_exp;
        n = int'(bc) + 1;
        if (n > 32) n = 32;
        h = int'(dv) + 1;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        rexp = (loop ? tx : srx) & mask;
        mexp = '0;
        for (int i = 0; i < n; i++) mexp[i] = lsb ? tx[i] : tx[n-1-i];
        mobs = '0;
        cs_exp = ~(8'd1 << addr);
        busy_c = 0; done_c = 0; lead_c = 0; edge_c = 0; samp = 0; sidx = 0;
        cs_bad = 0; seen_done = 0; prev = cpol;
        limit = h * (2 * n + 2) + 4;

        if (!chained) @(negedge clk);
        tx_data = tx; bit_count = bc; division_ratio = dv; CPOL = cpol; CPHA = cpha;
        lsb_first = lsb; default_val = defv; chipADDRS = addr; loopback = loop;
        start_trans = 1'b1;

        for (int cyc = 0; cyc < limit && !seen_done; cyc++) begin
            @(negedge clk);
            start_trans = 1'b0;
            if (cyc == 0) begin
                check("accept", {busy, CS}, {1'b1, cs_exp});
                if (!cpha) begin
                    s_miso = slave_bit(srx, n, 0, lsb);
                    sidx = 1;
                end
            end
            if (busy) busy_c++;
            if (CS !== (busy ? cs_exp : 8'hFF)) cs_bad = 1;
            if (SPI_SCLK !== prev) begin
                edge_c++;
                lead = (SPI_SCLK !== cpol);
                if (lead) lead_c++;
                if (lead != cpha) begin
                    if (samp < 32) mobs[samp] = MOSI;
                    samp++;
                end else begin
                    s_miso = slave_bit(srx, n, sidx, lsb);
                    sidx++;
                end
            end
            prev = SPI_SCLK;
            if (abort && edge_c == 5) begin
                rst = 1'b0;
                #1;
                check("rst_outputs", {CS, SPI_SCLK, MOSI, busy, done, rx_data},
                      {8'hFF, cpol, defv, 1'b0, 1'b0, 32'h0});
                repeat (3) begin
                    @(negedge clk);
                    if (done) done_c++;
                end
                rst = 1'b1;
                check("rst_no_done", 64'(done_c), 64'd0);
                return;
            end
            if (disturb && cyc == h * n) begin
                start_trans = 1'b1;
                tx_data = ~tx; bit_count = ~bc; chipADDRS = addr ^ 4'd1;
                lsb_first = ~lsb; division_ratio = dv + 8'd1;
            end
            if (done) begin
                seen_done = 1;
                done_c++;
                check("done_state", {busy, CS, SPI_SCLK, MOSI}, {1'b0, 8'hFF, cpol, defv});
                check("rx_data", 64'(rx_data), 64'(rexp));
                if (hold) start_trans = 1'b1;
            end
        end
        check("busy_cycles", 64'(busy_c), 64'(h * (2 * n + 2)));
        check("done_count", 64'(done_c), 64'd1);
        check("lead_edges", 64'(lead_c), 64'(n));
        check("mosi_stream", 64'(mobs), 64'(mexp));
        check("cs_select", 64'(cs_bad), 64'd0);
        if (!hold) begin
            @(negedge clk);
            check("done_pulse_end", {done, busy}, 2'b00);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, bcnt, d;
        bit prev;
        logic [31:0] t;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, CS, SPI_SCLK, MOSI, rx_data}, {1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 32'h0});
        rst = 1'b1;

        run(32'hA5, 5'd7, 8'd0, 0, 0, 0, 0, 4'd3, 1, 32'h0, 0, 0, 0, 0);

        for (int m = 0; m < 4; m++)
            run(32'h1234, 5'd15, 8'd2, m[1], m[0], 0, 1, 4'd2, 0, 32'hBEEF, 0, 0, 0, 0);

        run(32'h8000_0001, 5'd31, 8'd1, 0, 0, 1, 0, 4'd5, 1, 32'h0, 0, 0, 0, 0);

        // Out-of-range slave address: nothing may happen.
        @(negedge clk);
        chipADDRS = 4'd9; start_trans = 1'b1;
        e = 0;
        repeat (6) begin
            @(negedge clk);
            start_trans = 1'b0;
            if (busy || done || CS !== 8'hFF) e++;
        end
        check("bad_addr_ignored", 64'(e), 64'd0);

        run(32'hC3A5_F00F, 5'd23, 8'd1, 1, 0, 0, 1, 4'd6, 0, 32'h5A_1E2D, 0, 0, 1, 0);

        run(32'hFFFF_0000, 5'd15, 8'd1, 1, 1, 0, 1, 4'd1, 1, 32'h0, 0, 0, 0, 1);
        run(32'h0000_9C3B, 5'd15, 8'd1, 1, 1, 0, 1, 4'd1, 0, 32'h7E51, 0, 0, 0, 0);

        run(32'h3C, 5'd7, 8'd0, 0, 1, 0, 0, 4'd7, 0, 32'h96, 0, 1, 0, 0);
        run(32'hD2, 5'd7, 8'd0, 0, 1, 0, 0, 4'd0, 0, 32'h4B, 1, 0, 0, 0);

        for (int r = 0; r < 16; r++) begin
            run($urandom, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                4'($urandom_range(0, 7)), 1'($urandom), $urandom, 0, 0, 0, 0);
        end

        // 24-bit build with bit_count=31 clamps to 24 bits.
        @(negedge clk);
        t = $urandom;
        tx_data = t; bit_count = 5'd31; division_ratio = 8'd0; CPOL = 1'b0; CPHA = 1'b0;
        lsb_first = 1'b0; default_val = 1'b0; chipADDRS = 4'd1; start24 = 1'b1;
        e = 0; bcnt = 0; d = 0; prev = 1'b0;
        for (int c = 0; c < 120 && d == 0; c++) begin
            @(negedge clk);
            start24 = 1'b0;
            if (busy24) bcnt++;
            if (sclk24 && !prev) e++;
            prev = sclk24;
            if (done24) d = 1;
        end
        check("clamp_edges", 64'(e), 64'd24);
        check("clamp_busy", 64'(bcnt), 64'd50);
        check("clamp_done", 64'(d), 64'd1);
        check("clamp_rx", 64'(rx24), 64'(t[23:0]));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
